// File: rtl/gyro_pkg.sv
// gyro_pkg: shared state encoding, rate width and saturation limits for the gyro calibration block.
package gyro_pkg;
    localparam int RATE_W = 16;
    localparam logic signed [RATE_W-1:0] SAT_MAX = 16'sh7fff;
    localparam logic signed [RATE_W-1:0] SAT_MIN = 16'sh8000;
    typedef enum logic [1:0] {IDLE, CALIB, LATCH, RUN} state_t;
endpackage

// File: rtl/gyro_bias_axis.sv
// gyro_bias_axis: per-axis bias accumulation, bias latch and saturated correction.
// Deadband zeroing of small corrected rates is enabled by GYRO_DEADBAND_EN.
module gyro_bias_axis
    import gyro_pkg::*;
#(
    parameter int CAL_LOG2 = 8,
    parameter int DEADBAND = 100
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clr,
    input  logic              acc_en,
    input  logic              latch,
    input  logic              corr_en,
    input  logic [RATE_W-1:0] rate,
    output logic [RATE_W-1:0] adj
);
    localparam int ACC_W = RATE_W + CAL_LOG2;
`ifdef GYRO_DEADBAND_EN
    localparam logic signed [RATE_W:0] DB = (RATE_W+1)'(DEADBAND);
`endif
    logic signed [ACC_W-1:0]  acc;
    logic signed [RATE_W-1:0] bias;
    logic signed [RATE_W:0]   corr;
    logic signed [RATE_W-1:0] sat;
    logic [RATE_W-1:0]        nxt;
    assign corr = $signed({rate[RATE_W-1], rate}) - $signed({bias[RATE_W-1], bias});
    always_comb begin
        sat = (corr[RATE_W] != corr[RATE_W-1]) ? (corr[RATE_W] ? SAT_MIN : SAT_MAX) : corr[RATE_W-1:0];
`ifdef GYRO_DEADBAND_EN
        nxt = (corr <= DB && corr >= -DB) ? '0 : sat;
`else
        nxt = sat;
`endif
    end
    // Upper slice of the accumulator is the arithmetic shift by CAL_LOG2 (floor average).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc  <= '0;
            bias <= '0;
            adj  <= '0;
        end else begin
            if (clr)
                acc <= '0;
            else if (acc_en)
                acc <= acc + {{CAL_LOG2{rate[RATE_W-1]}}, rate};
            if (latch)
                bias <= acc[ACC_W-1:CAL_LOG2];
            if (corr_en)
                adj <= nxt;
        end
    end
endmodule

// File: rtl/gyro_cal_ctrl.sv
// gyro_cal_ctrl: gyro bias calibration FSM driving three per-axis correction slices.
// Optional deadband on corrected rates via GYRO_DEADBAND_EN.
module gyro_cal_ctrl
    import gyro_pkg::*;
#(
    parameter int CAL_LOG2 = 8,
    parameter int DEADBAND = 100
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              recal,
    input  logic              sample_valid,
    input  logic [RATE_W-1:0] rate_x,
    input  logic [RATE_W-1:0] rate_y,
    input  logic [RATE_W-1:0] rate_z,
    output logic [RATE_W-1:0] adj_x,
    output logic [RATE_W-1:0] adj_y,
    output logic [RATE_W-1:0] adj_z,
    output logic              adj_valid,
    output logic              integ_clr,
    output logic              busy,
    output logic              cal_done
);
    state_t state, state_nxt;
    logic [CAL_LOG2-1:0] cnt;
    logic clr, acc_en, latch, run_en;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            adj_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= clr ? '0 : acc_en ? cnt + 1'b1 : cnt;
            adj_valid <= run_en;
        end
    end
    // A recal in RUN takes priority and swallows any same-cycle sample.
    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        acc_en    = 1'b0;
        latch     = 1'b0;
        run_en    = 1'b0;
        case (state)
            IDLE:  if (start) begin
                state_nxt = CALIB;
                clr       = 1'b1;
            end
            CALIB: if (sample_valid) begin
                acc_en    = 1'b1;
                state_nxt = &cnt ? LATCH : CALIB;
            end
            LATCH: begin
                latch     = 1'b1;
                state_nxt = RUN;
            end
            RUN:   if (recal) begin
                state_nxt = CALIB;
                clr       = 1'b1;
            end else begin
                run_en    = sample_valid;
            end
            default: state_nxt = IDLE;
        endcase
    end
    assign integ_clr = state == LATCH;
    assign busy      = state == CALIB || state == LATCH;
    assign cal_done  = state == RUN;
    gyro_bias_axis #(.CAL_LOG2(CAL_LOG2), .DEADBAND(DEADBAND)) u_x (
        .clk(clk), .resetn(resetn), .clr(clr), .acc_en(acc_en), .latch(latch),
        .corr_en(run_en), .rate(rate_x), .adj(adj_x)
    );
    gyro_bias_axis #(.CAL_LOG2(CAL_LOG2), .DEADBAND(DEADBAND)) u_y (
        .clk(clk), .resetn(resetn), .clr(clr), .acc_en(acc_en), .latch(latch),
        .corr_en(run_en), .rate(rate_y), .adj(adj_y)
    );
    gyro_bias_axis #(.CAL_LOG2(CAL_LOG2), .DEADBAND(DEADBAND)) u_z (
        .clk(clk), .resetn(resetn), .clr(clr), .acc_en(acc_en), .latch(latch),
        .corr_en(run_en), .rate(rate_z), .adj(adj_z)
    );
endmodule

// File: tb/tb_gyro_cal_ctrl.sv
// tb_gyro_cal_ctrl: randomized and directed checks of gyro_cal_ctrl against a sample-level model.
module tb_gyro_cal_ctrl;
    localparam int CL = 2;
    localparam int DB = 100;
    localparam int NS = 1 << CL;
    localparam int M_IDLE = 0, M_CAL = 1, M_LAT = 2, M_RUN = 3;

    logic clk = 1'b0, resetn = 1'b0, start = 1'b0, recal = 1'b0, sample_valid = 1'b0;
    logic [15:0] rate_x = '0, rate_y = '0, rate_z = '0;
    logic [15:0] adj_x, adj_y, adj_z;
    logic adj_valid, integ_clr, busy, cal_done;

    int checks = 0, errors = 0;
    int mode;
    int nsamp;
    int sums[3];
    int bias[3];
    int exp_adj[3];
    int exp_valid;

    always #5 clk = ~clk;

    gyro_cal_ctrl #(.CAL_LOG2(CL), .DEADBAND(DB)) dut (
        .clk(clk), .resetn(resetn), .start(start), .recal(recal), .sample_valid(sample_valid),
        .rate_x(rate_x), .rate_y(rate_y), .rate_z(rate_z),
        .adj_x(adj_x), .adj_y(adj_y), .adj_z(adj_z),
        .adj_valid(adj_valid), .integ_clr(integ_clr), .busy(busy), .cal_done(cal_done)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int floor_div(input int s);
        int q = s / NS;
        if (s % NS != 0 && s < 0) q--;
        return q;
    endfunction

    function automatic int corr_of(input int r, input int b);
        int c = r - b;
        if (c > 32767) c = 32767;
        if (c < -32768) c = -32768;
`ifdef GYRO_DEADBAND_EN
        if (c <= DB && c >= -DB) c = 0;
`endif
        return c;
    endfunction

    function automatic int rnd_rate();
        int k = int'($urandom_range(0, 3));
        logic signed [15:0] v = 16'($urandom);
        if (k == 0) return int'(v);
        if (k == 1) return $urandom_range(0, 1) ? 32767 : -32768;
        if (k == 2) return int'($urandom_range(0, 400)) - 200;
        return int'(v) / 64;
    endfunction

    task automatic check_outputs();
        check("busy", int'(busy), int'(mode == M_CAL || mode == M_LAT));
        check("cal_done", int'(cal_done), int'(mode == M_RUN));
        check("integ_clr", int'(integ_clr), int'(mode == M_LAT));
        check("adj_valid", int'(adj_valid), exp_valid);
        check("adj_x", int'($signed(adj_x)), exp_adj[0]);
        check("adj_y", int'($signed(adj_y)), exp_adj[1]);
        check("adj_z", int'($signed(adj_z)), exp_adj[2]);
    endtask

    task automatic cyc(input logic sv, input logic st, input logic rc, input int x, input int y, input int z);
        int r[3];
        r = '{x, y, z};
        sample_valid = sv;
        start = st;
        recal = rc;
        rate_x = 16'(x);
        rate_y = 16'(y);
        rate_z = 16'(z);
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        start = 1'b0;
        recal = 1'b0;
        exp_valid = 0;
        case (mode)
            M_IDLE: if (st) begin
                mode = M_CAL;
                sums = '{0, 0, 0};
                nsamp = 0;
            end
            M_CAL: if (sv) begin
                for (int i = 0; i < 3; i++) sums[i] += r[i];
                nsamp++;
                if (nsamp == NS) begin
                    for (int i = 0; i < 3; i++) bias[i] = floor_div(sums[i]);
                    mode = M_LAT;
                end
            end
            M_LAT: mode = M_RUN;
            default: if (rc) begin
                mode = M_CAL;
                sums = '{0, 0, 0};
                nsamp = 0;
            end else if (sv) begin
                exp_valid = 1;
                for (int i = 0; i < 3; i++) exp_adj[i] = corr_of(r[i], bias[i]);
            end
        endcase
        check_outputs();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #2;
        mode = M_IDLE;
        exp_valid = 0;
        exp_adj = '{0, 0, 0};
        bias = '{0, 0, 0};
        check_outputs();
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic rnd_cyc(input logic rc);
        cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) == 0), rc, rnd_rate(), rnd_rate(), rnd_rate());
    endtask

    initial begin
        mode = M_IDLE;
        exp_valid = 0;
        exp_adj = '{0, 0, 0};
        bias = '{0, 0, 0};
        #1;
        check_outputs();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        // Samples and recal without start are ignored in IDLE.
        repeat (3) cyc(1'b1, 1'b0, 1'b1, rnd_rate(), rnd_rate(), rnd_rate());
        // Directed calibration: bias_x = 13, bias_y = -13.
        cyc(1'b0, 1'b1, 1'b0, 0, 0, 0);
        cyc(1'b1, 1'b0, 1'b0, 10, -13, rnd_rate());
        cyc(1'b1, 1'b0, 1'b0, 12, -13, rnd_rate());
        cyc(1'b1, 1'b0, 1'b0, 14, -13, rnd_rate());
        cyc(1'b1, 1'b0, 1'b0, 16, -13, rnd_rate());
        check("latch_pulse", int'(integ_clr), 1);
        cyc(1'b1, 1'b0, 1'b0, 500, 500, 500);
        check("run_after_latch", int'(cal_done), 1);
        cyc(1'b1, 1'b0, 1'b0, 200, 32767, rnd_rate());
        check("bias13_adj_x", int'($signed(adj_x)), 187);
        check("sat_hi_adj_y", int'($signed(adj_y)), 32767);
        cyc(1'b0, 1'b0, 1'b0, 0, 0, 0);
        check("hold_adj_x", int'($signed(adj_x)), 187);
        cyc(1'b1, 1'b0, 1'b0, 113, 0, 0);
`ifdef GYRO_DEADBAND_EN
        check("db_113", int'($signed(adj_x)), 0);
`else
        check("db_113", int'($signed(adj_x)), 100);
`endif
        cyc(1'b1, 1'b0, 1'b0, 114, 0, 0);
        check("db_114", int'($signed(adj_x)), 101);
        // Recalibrate with bias_y = 13 for negative saturation.
        cyc(1'b0, 1'b0, 1'b1, 0, 0, 0);
        repeat (NS) cyc(1'b1, 1'b0, 1'b0, 13, 13, rnd_rate());
        cyc(1'b0, 1'b0, 1'b0, 0, 0, 0);
        cyc(1'b1, 1'b0, 1'b0, 0, -32768, 0);
        check("sat_lo_adj_y", int'($signed(adj_y)), -32768);
        // Randomized calibrate/run rounds.
        for (int round = 0; round < 8; round++) begin
            cyc(1'b0, 1'b0, 1'b1, 0, 0, 0);
            for (int n = 0; n < 200 && mode != M_RUN; n++) rnd_cyc(1'b0);
            check("reached_run", mode, M_RUN);
            repeat (30) rnd_cyc(1'b0);
        end
        // Recal with a same-cycle sample: sample dropped, counter restarts.
        cyc(1'b1, 1'b0, 1'b1, 1000, 1000, 1000);
        check("recal_busy", int'(busy), 1);
        repeat (NS - 1) cyc(1'b1, 1'b0, 1'b0, rnd_rate(), rnd_rate(), rnd_rate());
        check("recal_cnt_no_latch", int'(integ_clr), 0);
        cyc(1'b1, 1'b0, 1'b0, rnd_rate(), rnd_rate(), rnd_rate());
        check("recal_cnt_latch", int'(integ_clr), 1);
        repeat (10) rnd_cyc(1'b0);
        // Reset midway through a calibration.
        cyc(1'b0, 1'b0, 1'b1, 0, 0, 0);
        cyc(1'b1, 1'b0, 1'b0, 30000, 30000, 30000);
        cyc(1'b1, 1'b0, 1'b0, 30000, 30000, 30000);
        do_reset();
        repeat (4) cyc(1'b1, 1'b0, 1'b1, rnd_rate(), rnd_rate(), rnd_rate());
        cyc(1'b0, 1'b1, 1'b0, 0, 0, 0);
        for (int n = 0; n < 200 && mode != M_RUN; n++) rnd_cyc(1'b0);
        check("post_reset_run", mode, M_RUN);
        repeat (20) rnd_cyc(1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
